// File: rtl/lcd_diag_pkg.sv
// Shared constants and types for the LCD diagnostic sequencer.
package lcd_diag_pkg;

   localparam int unsigned MODE_W      = 2;
   localparam int unsigned TILE_W      = 7;
   localparam int unsigned FRAME_W     = 16;
   localparam int unsigned LED_W       = 6;
   localparam int unsigned DEF_TILES_X = 60;
   localparam int unsigned DEF_TILES_Y = 34;

   typedef enum logic [MODE_W-1:0] {
      MODE_CHECKER = 2'd0,
      MODE_CURSOR  = 2'd1,
      MODE_BARS    = 2'd2,
      MODE_SOLID   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_e;

   // Next pattern mode, wrapping after the last implemented mode.
   function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m,
                                                   input int unsigned num_modes);
      return (32'(m) >= num_modes - 1) ? MODE_W'(MODE_CHECKER) : m + MODE_W'(1);
   endfunction

endpackage

// File: rtl/lcd_diag_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop sync, stable counter, one-cycle press event.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
   input  logic clk_27mhz,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic [CNT_W-1:0] cnt;

   // Counter runs only while the synced input differs from the accepted level.
   always_ff @(posedge clk_27mhz) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            cnt   <= '0;
            level <= sync2;
            press <= ~sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/lcd_diag_sequencer.sv
// Frame-synchronous mode/cursor/pause controller for the LCD diagnostic datapath.
module lcd_diag_sequencer
   import lcd_diag_pkg::*;
#(
   parameter int unsigned TILES_X         = DEF_TILES_X,
   parameter int unsigned TILES_Y         = DEF_TILES_Y,
   parameter int unsigned NUM_MODES       = 4,
   parameter int unsigned DWELL_FRAMES    = 120,
   parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
   input  logic               clk_27mhz,
   input  logic               reset,
   input  logic               in_frame_tick,
   input  logic               in_btn_next_n,
   input  logic               in_btn_pause_n,
   output logic [MODE_W-1:0]  out_mode,
   output logic [TILE_W-1:0]  out_xtile,
   output logic [TILE_W-1:0]  out_ytile,
   output logic [FRAME_W-1:0] out_frame,
   output logic               out_paused,
   output logic               out_mode_change,
   output logic [LED_W-1:0]   out_led
);

   localparam int unsigned DW = $clog2(DWELL_FRAMES + 1);

   state_e             state;
   state_e             state_nx;
   logic               tick_s1;
   logic               tick_s2;
   logic               tick_s3;
   logic               frame_pulse;
   logic               next_press;
   logic               pause_press;
   logic [DW-1:0]      dwell;
   logic [DW-1:0]      dwell_nx;
   logic [MODE_W-1:0]  mode_nx;
   logic [TILE_W-1:0]  xtile_nx;
   logic [TILE_W-1:0]  ytile_nx;
   logic [FRAME_W-1:0] frame_nx;
   logic               advance;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
      .clk_27mhz (clk_27mhz),
      .reset     (reset),
      .btn_n     (in_btn_next_n),
      .press     (next_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pause (
      .clk_27mhz (clk_27mhz),
      .reset     (reset),
      .btn_n     (in_btn_pause_n),
      .press     (pause_press)
   );

   // Sync chain resets high so a tick already asserted at reset is not a new frame.
   assign frame_pulse = tick_s2 & ~tick_s3;

   // Next-state: frame handling uses the pre-toggle state.
   always_comb begin
      state_nx = state;
      mode_nx  = out_mode;
      xtile_nx = out_xtile;
      ytile_nx = out_ytile;
      frame_nx = out_frame;
      dwell_nx = dwell;
      advance  = 1'b0;

      if (pause_press) begin
         state_nx = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
      end

      if (frame_pulse) begin
         frame_nx = out_frame + FRAME_W'(1);
         if (state == ST_RUN) begin
            if (out_xtile == TILE_W'(TILES_X - 1)) begin
               xtile_nx = '0;
               ytile_nx = (out_ytile == TILE_W'(TILES_Y - 1)) ? '0 : out_ytile + TILE_W'(1);
            end else begin
               xtile_nx = out_xtile + TILE_W'(1);
            end
            if (dwell == DW'(DWELL_FRAMES - 1)) begin
               dwell_nx = '0;
               advance  = 1'b1;
            end else begin
               dwell_nx = dwell + DW'(1);
            end
         end
      end

      // A press coinciding with dwell expiry still yields a single advance.
      if (next_press) begin
         dwell_nx = '0;
         advance  = 1'b1;
      end

      if (advance) begin
         mode_nx = next_mode(out_mode, NUM_MODES);
      end
   end

   always_ff @(posedge clk_27mhz) begin
      if (reset) begin
         state           <= ST_RUN;
         tick_s1         <= 1'b1;
         tick_s2         <= 1'b1;
         tick_s3         <= 1'b1;
         dwell           <= '0;
         out_mode        <= MODE_W'(MODE_CHECKER);
         out_xtile       <= '0;
         out_ytile       <= '0;
         out_frame       <= '0;
         out_paused      <= 1'b0;
         out_mode_change <= 1'b0;
         out_led         <= '1;
      end else begin
         state           <= state_nx;
         tick_s1         <= in_frame_tick;
         tick_s2         <= tick_s1;
         tick_s3         <= tick_s2;
         dwell           <= dwell_nx;
         out_mode        <= mode_nx;
         out_xtile       <= xtile_nx;
         out_ytile       <= ytile_nx;
         out_frame       <= frame_nx;
         out_paused      <= (state_nx == ST_PAUSE);
         out_mode_change <= advance;
         out_led         <= ~{(state_nx == ST_PAUSE), mode_nx, xtile_nx[2:0]};
      end
   end

endmodule

// File: tb/tb_lcd_diag_sequencer.sv
// Randomized self-checking bench for lcd_diag_sequencer against an event-level model.
module tb_lcd_diag_sequencer;

   localparam int DEB   = 4;
   localparam int DWELL = 3;
   localparam int NX    = 60;
   localparam int NY    = 34;
   localparam int NM    = 4;

   logic        clk_27mhz = 1'b0;
   logic        reset = 1'b1;
   logic        in_frame_tick = 1'b0;
   logic        in_btn_next_n = 1'b1;
   logic        in_btn_pause_n = 1'b1;
   logic [1:0]  out_mode;
   logic [6:0]  out_xtile;
   logic [6:0]  out_ytile;
   logic [15:0] out_frame;
   logic        out_paused;
   logic        out_mode_change;
   logic [5:0]  out_led;

   int total = 0;
   int bad = 0;
   int pulse_cnt = 0;

   // Model: cursor as a linear index over the tile grid, counts as plain integers.
   int m_frame, m_idx, m_dwell, m_mode;
   bit m_paused;

   lcd_diag_sequencer #(
      .TILES_X(NX), .TILES_Y(NY), .NUM_MODES(NM),
      .DWELL_FRAMES(DWELL), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk_27mhz       (clk_27mhz),
      .reset           (reset),
      .in_frame_tick   (in_frame_tick),
      .in_btn_next_n   (in_btn_next_n),
      .in_btn_pause_n  (in_btn_pause_n),
      .out_mode        (out_mode),
      .out_xtile       (out_xtile),
      .out_ytile       (out_ytile),
      .out_frame       (out_frame),
      .out_paused      (out_paused),
      .out_mode_change (out_mode_change),
      .out_led         (out_led)
   );

   always #5 clk_27mhz = ~clk_27mhz;

   always @(negedge clk_27mhz) if (out_mode_change === 1'b1) pulse_cnt++;

   function automatic void m_reset();
      m_frame = 0; m_idx = 0; m_dwell = 0; m_mode = 0; m_paused = 0;
   endfunction

   // One frame, optionally with a next press landing in the same cycle.
   function automatic void m_frame_ev(input bit with_next);
      bit adv;
      adv = with_next;
      m_frame = (m_frame + 1) % 65536;
      if (!m_paused) begin
         m_idx = (m_idx + 1) % (NX * NY);
         m_dwell = m_dwell + 1;
         if (m_dwell == DWELL) adv = 1;
      end
      if (adv) begin
         m_dwell = 0;
         m_mode = (m_mode + 1) % NM;
      end
   endfunction

   function automatic void m_next_ev();
      m_dwell = 0;
      m_mode = (m_mode + 1) % NM;
   endfunction

   task automatic apply_reset();
      @(posedge clk_27mhz); #1 reset = 1'b1;
      repeat (2) @(posedge clk_27mhz);
      #1 reset = 1'b0;
      m_reset();
   endtask

   task automatic do_tick(input int gap);
      @(posedge clk_27mhz); #1 in_frame_tick = 1'b1;
      repeat (2) @(posedge clk_27mhz);
      #1 in_frame_tick = 1'b0;
      repeat (gap) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      m_frame_ev(1'b0);
   endtask

   task automatic press_btn(input bit is_pause);
      @(posedge clk_27mhz);
      #1 if (is_pause) in_btn_pause_n = 1'b0; else in_btn_next_n = 1'b0;
      repeat (DEB + 8) @(posedge clk_27mhz);
      #1 in_btn_pause_n = 1'b1; in_btn_next_n = 1'b1;
      repeat (DEB + 6) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      if (is_pause) m_paused = ~m_paused; else m_next_ev();
   endtask

   task automatic test_reset();
      in_frame_tick = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      total++; if (out_frame !== 16'd0 || out_mode !== 2'd0 || out_xtile !== 7'd0 || out_ytile !== 7'd0)
         begin bad++; $display("FAIL reset_counts: frame=%0d mode=%0d x=%0d y=%0d required all 0", out_frame, out_mode, out_xtile, out_ytile); end
      total++; if (out_paused !== 1'b0 || out_mode_change !== 1'b0)
         begin bad++; $display("FAIL reset_flags: paused=%b change=%b required 0 0", out_paused, out_mode_change); end
      total++; if (out_led !== 6'b111111)
         begin bad++; $display("FAIL reset_led: got %b required 111111", out_led); end
      reset = 1'b0;
      m_reset();
      repeat (4) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      total++; if (out_frame !== 16'd0)
         begin bad++; $display("FAIL held_tick_no_pulse: frame=%0d required 0", out_frame); end
      in_frame_tick = 1'b0;
      repeat (3) @(posedge clk_27mhz);
      for (int i = 0; i < 5; i++) do_tick(3);
      total++; if (out_frame !== 16'(m_frame) || m_frame != 5)
         begin bad++; $display("FAIL five_ticks_frame: got %0d required %0d", out_frame, m_frame); end
      total++; if (out_xtile !== 7'(m_idx % NX) || out_ytile !== 7'(m_idx / NX))
         begin bad++; $display("FAIL five_ticks_cursor: got x=%0d y=%0d required x=%0d y=%0d", out_xtile, out_ytile, m_idx % NX, m_idx / NX); end
      total++; if (out_mode !== 2'(m_mode))
         begin bad++; $display("FAIL five_ticks_mode: got %0d required %0d", out_mode, m_mode); end
   endtask

   task automatic test_cursor_wrap();
      apply_reset();
      for (int i = 1; i <= NX * NY; i++) begin
         do_tick($urandom_range(3, 5));
         total++; if (out_xtile !== 7'(m_idx % NX) || out_ytile !== 7'(m_idx / NX))
            begin bad++; $display("FAIL cursor_tick%0d: got x=%0d y=%0d required x=%0d y=%0d", i, out_xtile, out_ytile, m_idx % NX, m_idx / NX); end
      end
      total++; if (out_xtile !== 7'd0 || out_ytile !== 7'd0 || out_frame !== 16'd2040)
         begin bad++; $display("FAIL grid_wrap: got x=%0d y=%0d frame=%0d required 0 0 2040", out_xtile, out_ytile, out_frame); end
   endtask

   task automatic test_dwell();
      int p0;
      apply_reset();
      p0 = pulse_cnt;
      for (int i = 0; i < DWELL; i++) do_tick(3);
      total++; if (out_mode !== 2'd1 || pulse_cnt - p0 != 1)
         begin bad++; $display("FAIL dwell_advance: mode=%0d pulses=%0d required 1 1", out_mode, pulse_cnt - p0); end
      for (int i = 0; i < 3 * DWELL; i++) do_tick(3);
      total++; if (out_mode !== 2'(m_mode) || m_mode != 0 || pulse_cnt - p0 != 4)
         begin bad++; $display("FAIL dwell_wrap: mode=%0d pulses=%0d required 0 4", out_mode, pulse_cnt - p0); end
   endtask

   task automatic test_pause();
      int p0;
      apply_reset();
      press_btn(1'b1);
      total++; if (out_paused !== 1'b1 || out_led !== ~{1'b1, 2'd0, 3'd0})
         begin bad++; $display("FAIL pause_enter: paused=%b led=%b required 1 %b", out_paused, out_led, ~{1'b1, 2'd0, 3'd0}); end
      for (int i = 0; i < 4; i++) do_tick(4);
      total++; if (out_frame !== 16'd4 || out_xtile !== 7'd0 || out_ytile !== 7'd0 || out_mode !== 2'd0)
         begin bad++; $display("FAIL paused_frozen: frame=%0d x=%0d y=%0d mode=%0d required 4 0 0 0", out_frame, out_xtile, out_ytile, out_mode); end
      p0 = pulse_cnt;
      press_btn(1'b0);
      total++; if (out_mode !== 2'(m_mode) || pulse_cnt - p0 != 1 || out_paused !== 1'b1)
         begin bad++; $display("FAIL paused_next: mode=%0d pulses=%0d paused=%b required %0d 1 1", out_mode, pulse_cnt - p0, out_paused, m_mode); end
      press_btn(1'b1);
      do_tick(3);
      total++; if (out_paused !== 1'b0 || out_xtile !== 7'(m_idx % NX))
         begin bad++; $display("FAIL pause_exit: paused=%b x=%0d required 0 %0d", out_paused, out_xtile, m_idx % NX); end
   endtask

   task automatic test_glitch_and_coincide();
      int p0;
      apply_reset();
      p0 = pulse_cnt;
      for (int g = 0; g < 3; g++) begin
         @(posedge clk_27mhz); #1 in_btn_next_n = 1'b0;
         repeat (3) @(posedge clk_27mhz);
         #1 in_btn_next_n = 1'b1;
         repeat (2) @(posedge clk_27mhz);
      end
      @(negedge clk_27mhz);
      total++; if (out_mode !== 2'd0 || pulse_cnt != p0)
         begin bad++; $display("FAIL glitch_reject: mode=%0d pulses=%0d required 0 0", out_mode, pulse_cnt - p0); end
      @(posedge clk_27mhz); #1 in_btn_next_n = 1'b0;
      repeat (10) @(posedge clk_27mhz);
      #1 in_btn_next_n = 1'b1;
      repeat (DEB + 6) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      m_next_ev();
      total++; if (out_mode !== 2'(m_mode) || pulse_cnt - p0 != 1)
         begin bad++; $display("FAIL glitch_then_hold: mode=%0d pulses=%0d required %0d 1", out_mode, pulse_cnt - p0, m_mode); end
      // Line the press event up with the frame that expires the dwell.
      do_tick(3);
      do_tick(3);
      p0 = pulse_cnt;
      @(posedge clk_27mhz); #1 in_btn_next_n = 1'b0;
      repeat (5) @(posedge clk_27mhz);
      #1 in_frame_tick = 1'b1;
      repeat (2) @(posedge clk_27mhz);
      #1 in_frame_tick = 1'b0;
      repeat (DEB + 4) @(posedge clk_27mhz);
      #1 in_btn_next_n = 1'b1;
      repeat (DEB + 6) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      m_frame_ev(1'b1);
      total++; if (out_mode !== 2'(m_mode) || pulse_cnt - p0 != 1)
         begin bad++; $display("FAIL coincide_single: mode=%0d pulses=%0d required %0d 1", out_mode, pulse_cnt - p0, m_mode); end
      for (int i = 0; i < DWELL; i++) begin
         do_tick(3);
         total++; if (out_mode !== 2'(m_mode))
            begin bad++; $display("FAIL coincide_dwell%0d: mode=%0d required %0d", i, out_mode, m_mode); end
      end
   endtask

   task automatic test_reset_mid_debounce();
      int p0;
      apply_reset();
      do_tick(3);
      do_tick(3);
      @(posedge clk_27mhz); #1 in_btn_next_n = 1'b0;
      repeat (3) @(posedge clk_27mhz);
      #1 reset = 1'b1;
      @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      total++; if (out_frame !== 16'd0 || out_mode !== 2'd0 || out_xtile !== 7'd0 || out_ytile !== 7'd0 || out_paused !== 1'b0 || out_mode_change !== 1'b0)
         begin bad++; $display("FAIL midrun_reset: frame=%0d mode=%0d x=%0d y=%0d paused=%b change=%b required all 0", out_frame, out_mode, out_xtile, out_ytile, out_paused, out_mode_change); end
      total++; if (out_led !== 6'b111111)
         begin bad++; $display("FAIL midrun_reset_led: got %b required 111111", out_led); end
      reset = 1'b0;
      m_reset();
      p0 = pulse_cnt;
      for (int k = 1; k <= DEB + 4; k++) begin
         @(posedge clk_27mhz);
         @(negedge clk_27mhz);
         if (k == DEB + 4) m_next_ev();
         total++; if (out_mode !== 2'(m_mode))
            begin bad++; $display("FAIL post_reset_debounce_k%0d: mode=%0d required %0d", k, out_mode, m_mode); end
      end
      #1 in_btn_next_n = 1'b1;
      repeat (DEB + 6) @(posedge clk_27mhz);
      @(negedge clk_27mhz);
      total++; if (pulse_cnt - p0 != 1 || out_mode !== 2'(m_mode))
         begin bad++; $display("FAIL post_reset_press: pulses=%0d mode=%0d required 1 %0d", pulse_cnt - p0, out_mode, m_mode); end
   endtask

   task automatic test_random();
      int p0, mp, r;
      logic [5:0] exp_led;
      apply_reset();
      mp = 0;
      p0 = pulse_cnt;
      for (int it = 0; it < 80; it++) begin
         r = $urandom_range(0, 9);
         if (r < 7) begin
            int pm = m_mode;
            do_tick($urandom_range(3, 6));
            if (pm != m_mode) mp++;
         end else if (r < 9) begin
            press_btn(1'b0);
            mp++;
         end else begin
            press_btn(1'b1);
         end
         exp_led = ~{m_paused, 2'(m_mode), 3'(m_idx % NX)};
         total++; if (out_mode !== 2'(m_mode) || out_paused !== m_paused || out_frame !== 16'(m_frame))
            begin bad++; $display("FAIL rand%0d_state: mode=%0d paused=%b frame=%0d required %0d %b %0d", it, out_mode, out_paused, out_frame, m_mode, m_paused, m_frame); end
         total++; if (out_xtile !== 7'(m_idx % NX) || out_ytile !== 7'(m_idx / NX))
            begin bad++; $display("FAIL rand%0d_cursor: x=%0d y=%0d required %0d %0d", it, out_xtile, out_ytile, m_idx % NX, m_idx / NX); end
         total++; if (out_led !== exp_led || pulse_cnt - p0 != mp)
            begin bad++; $display("FAIL rand%0d_led_pulses: led=%b pulses=%0d required %b %0d", it, out_led, pulse_cnt - p0, exp_led, mp); end
      end
   endtask

   initial begin
      test_reset();
      test_cursor_wrap();
      test_dwell();
      test_pause();
      test_glitch_and_coincide();
      test_reset_mid_debounce();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcd_diag_sequencer.md
# lcd_diag_sequencer

Frame-synchronous controller for the 480x272 LCD diagnostic datapath. It runs in the clk_27mhz domain and takes the panel-timing frame strobe plus two raw push-buttons. It decides which test pattern is active, where the 8x8 highlight cursor sits on the 60x34 tile grid, and whether the sequence is running or paused. The pixel pattern generator consumes its outputs as configuration; the board LEDs show its status.

## Interface
Parameters:
- TILES_X, 60, cursor grid width in tiles
- TILES_Y, 34, cursor grid height in tiles
- NUM_MODES, 4, number of pattern modes (2..4)
- DWELL_FRAMES, 120, frames per mode before auto-advance (≥1)
- DEBOUNCE_CYCLES, 270000, clk_27mhz cycles a button must be stable (10 ms)

Ports:
- clk_27mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- in_frame_tick  in  1  frame strobe from the 9 MHz timing domain; each high pulse lasts ≥2 clk_27mhz cycles
- in_btn_next_n  in  1  raw button, active-low: advance mode
- in_btn_pause_n  in  1  raw button, active-low: toggle pause
- out_mode  out  2  active pattern mode
- out_xtile  out  7  cursor column, 0..TILES_X-1
- out_ytile  out  7  cursor row, 0..TILES_Y-1
- out_frame  out  16  free-running frame count
- out_paused  out  1  1 = PAUSE state
- out_mode_change  out  1  one-cycle pulse on every mode change
- out_led  out  6  active-low status: ~{out_paused, out_mode, out_xtile[2:0]}

Reset: reset, synchronous, active-high; clock: clk_27mhz.

## Operation
- Frame sync: in_frame_tick passes through 3 flops (s1,s2,s3); frame_pulse = s2 & ~s3. All three flops reset to 1, so a tick that is already high at reset produces no pulse.
- Buttons: each uses a 2-flop sync (reset to 1, released) and a stable-counter.
  - The counter clears on any change of the synced level.
  - The debounced level updates once the input has been stable for DEBOUNCE_CYCLES cycles.
  - A debounced 1→0 transition gives a one-cycle press event. Releases produce no event.
- State machine has two states, RUN (reset state) and PAUSE.
  - A pause press toggles RUN↔PAUSE.
- On frame_pulse, in either state: out_frame increments, wrapping 0xFFFF→0.
- On frame_pulse in RUN only:
  - Cursor: xtile increments. At xtile = TILES_X-1, xtile→0 and ytile increments.
  - At xtile = TILES_X-1 with ytile = TILES_Y-1, both wrap to 0 on the same edge. ytile never changes while xtile is not wrapping.
  - Dwell: the counter increments. At DWELL_FRAMES-1 it clears and the mode advances.
- In PAUSE, the cursor and dwell counter are frozen.
- Next press, in either state: the mode advances and the dwell counter clears. In PAUSE the mode still advances.
- Mode advance: out_mode+1, wrapping NUM_MODES-1→0, and out_mode_change pulses for exactly one cycle.
- Simultaneous events in one cycle:
  - Next press together with dwell expiry: a single advance and a single pulse.
  - Pause press together with frame_pulse: the frame is processed using the pre-toggle state.

## Timing
- Reset values:
  - out_mode, out_xtile, out_ytile, out_frame, out_paused, out_mode_change, dwell counter and debounce counters all 0.
  - State RUN; out_led = 6'b111111.
- in_frame_tick rising edge sampled at edge N: frame_pulse is high during cycle N+1→N+2, and the outputs update at edge N+2.
- Button press event: DEBOUNCE_CYCLES+3 cycles after the raw falling edge, with the input held stable. Mode/state outputs update on the edge after the event.
- All outputs are registered; out_led is a registered copy of its source fields.
- Reset asserted mid-operation forces every reset value on the next edge, including mid-debounce and mid-dwell.

## Structure
- Package lcd_diag_pkg holds:
  - mode constants MODE_CHECKER=0, MODE_CURSOR=1, MODE_BARS=2, MODE_SOLID=3;
  - state encoding ST_RUN/ST_PAUSE;
  - default tile dimensions 60/34.
- Sub-module btn_debounce (sync + stable counter + press-event pulse, parameter DEBOUNCE_CYCLES) is instantiated twice.
- The dwell counter width is $clog2(DWELL_FRAMES+1).

## Test plan
Run the bench with DEBOUNCE_CYCLES=4, DWELL_FRAMES=3.
- Reset with in_frame_tick held high, then 5 frame ticks → no pulse during reset; out_frame=5, xtile=5, ytile=0, mode=0.
- 60×34 ticks from reset → ytile increments at each xtile 59→0; at tick 2040, xtile=0 and ytile=0 on the same edge.
- 3 ticks in RUN → mode 0→1 with one out_mode_change pulse; 12 ticks from reset → mode back to 0.
- Pause press, then 4 ticks → out_paused=1, out_frame=4, xtile/ytile/mode unchanged; next press while paused → mode+1 with one pulse.
- Raw next button bouncing 3-cycle glitches, then held low for 10 cycles → exactly one advance; next press coinciding with a dwell-expiry frame → single advance.
- Reset asserted mid-debounce with 2 dwell frames counted → all outputs 0 and out_led=111111 on the next edge; the following press needs the full debounce time.
